// File: rtl/reaction_pkg.sv
// reaction_pkg
// Shared definitions for the reaction game controller: game state encoding,
// display-select and difficulty codes, LFSR constants and small helpers.
// No ports (package).
package reaction_pkg;

    typedef enum logic [2:0] {
        MENU   = 3'd0,
        WAIT   = 3'd1,
        GO     = 3'd2,
        RESULT = 3'd3,
        FAULT  = 3'd4
    } state_t;

    // Display driver select codes
    localparam logic [1:0] SEL_MENU   = 2'd0;
    localparam logic [1:0] SEL_COUNT  = 2'd1;
    localparam logic [1:0] SEL_RESULT = 2'd2;
    localparam logic [1:0] SEL_FAULT  = 2'd3;

    // Difficulty codes; 2'b11 is never produced
    localparam logic [1:0] MODE_EASY = 2'b00;
    localparam logic [1:0] MODE_REG  = 2'b01;
    localparam logic [1:0] MODE_HARD = 2'b10;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [1:0] mode_next(input logic [1:0] cur);
        case (cur)
            MODE_EASY: return MODE_REG;
            MODE_REG:  return MODE_HARD;
            default:   return MODE_EASY;
        endcase
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner
// Conditions one raw push-button: two-flop synchronizer, counting debouncer,
// and a one-cycle pulse on each rising edge of the debounced level.
// Ports:
//   clk_500Hz  in   system tick clock
//   rst        in   asynchronous active-high reset
//   i_btn      in   raw asynchronous button
//   o_pulse    out  one-cycle pulse on debounced press
module btn_conditioner #(
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic clk_500Hz,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_500Hz or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Count consecutive disagreeing samples; the Nth one flips the level.
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_pulse = r_level & ~r_level_d;

endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl
// Reaction game controller on the 500 Hz tick (1 cycle = 2 ms): conditions
// the buttons, runs the MENU/WAIT/GO/RESULT/FAULT machine and times the
// reaction in ms. The reported time excludes the fixed button latency.
// Ports:
//   clk_500Hz  in   system tick clock
//   rst        in   asynchronous active-high reset
//   btn_mode   in   raw mode button
//   btn_start  in   raw start/return button
//   btn_react  in   raw reaction button
//   number     out  reaction time / timeout in ms
//   select     out  display state (mode name, live count, result, fault)
//   mode       out  difficulty (easy, regular, hard)
//   led_go     out  high while the player must react
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 10,
    parameter int DELAY_BASE     = 500,
    parameter int LIMIT_EASY_MS  = 2000,
    parameter int LIMIT_REG_MS   = 1000,
    parameter int LIMIT_HARD_MS  = 500
) (
    input  logic        clk_500Hz,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_start,
    input  logic        btn_react,
    output logic [13:0] number,
    output logic [1:0]  select,
    output logic [1:0]  mode,
    output logic        led_go
);

    logic w_mode_p;
    logic w_start_p;
    logic w_react_p;

    state_t      r_state,  w_state_nxt;
    logic [15:0] r_lfsr;
    logic [15:0] r_delay,  w_delay_nxt;
    logic [13:0] r_number, w_number_nxt;
    logic [1:0]  r_mode,   w_mode_nxt;
    logic [1:0]  r_select, w_select_nxt;
    logic        r_led,    w_led_nxt;
    logic [13:0] w_limit;

    btn_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_btn_mode (
        .clk_500Hz(clk_500Hz), .rst(rst), .i_btn(btn_mode),  .o_pulse(w_mode_p)
    );
    btn_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_btn_start (
        .clk_500Hz(clk_500Hz), .rst(rst), .i_btn(btn_start), .o_pulse(w_start_p)
    );
    btn_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_btn_react (
        .clk_500Hz(clk_500Hz), .rst(rst), .i_btn(btn_react), .o_pulse(w_react_p)
    );

    always_comb begin
        case (r_mode)
            MODE_HARD: w_limit = 14'(LIMIT_HARD_MS);
            MODE_REG:  w_limit = 14'(LIMIT_REG_MS);
            default:   w_limit = 14'(LIMIT_EASY_MS);
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_500Hz or posedge rst) begin
        if (rst) begin
            r_state  <= MENU;
            r_lfsr   <= LFSR_SEED;
            r_delay  <= '0;
            r_number <= '0;
            r_mode   <= MODE_EASY;
            r_select <= SEL_MENU;
            r_led    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lfsr   <= lfsr_next(r_lfsr);
            r_delay  <= w_delay_nxt;
            r_number <= w_number_nxt;
            r_mode   <= w_mode_nxt;
            r_select <= w_select_nxt;
            r_led    <= w_led_nxt;
        end
    end

    // Next state: a react pulse beats both WAIT expiry and the GO limit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MENU:   if (w_start_p) w_state_nxt = WAIT;
            WAIT: begin
                if (w_react_p)          w_state_nxt = FAULT;
                else if (r_delay == '0) w_state_nxt = GO;
            end
            GO: begin
                if (w_react_p)              w_state_nxt = RESULT;
                else if (r_number == w_limit) w_state_nxt = FAULT;
            end
            RESULT, FAULT: if (w_start_p) w_state_nxt = MENU;
            default: w_state_nxt = MENU;
        endcase
    end

    // Datapath and output decode; outputs are decoded from the next state
    // so they register on the same edge as the state change.
    always_comb begin
        w_delay_nxt  = r_delay;
        w_number_nxt = r_number;
        w_mode_nxt   = r_mode;
        case (r_state)
            MENU: begin
                // start wins over a simultaneous mode press
                if (w_start_p)
                    w_delay_nxt = 16'(DELAY_BASE) + {6'd0, r_lfsr[9:0]};
                else if (w_mode_p)
                    w_mode_nxt = mode_next(r_mode);
            end
            WAIT: begin
                if (!w_react_p && r_delay != '0) w_delay_nxt = r_delay - 16'd1;
            end
            GO: begin
                if (!w_react_p && r_number != w_limit) w_number_nxt = r_number + 14'd2;
            end
            RESULT, FAULT: begin
                if (w_start_p) w_number_nxt = '0;
            end
            default: w_number_nxt = '0;
        endcase

        case (w_state_nxt)
            WAIT, GO: w_select_nxt = SEL_COUNT;
            RESULT:   w_select_nxt = SEL_RESULT;
            FAULT:    w_select_nxt = SEL_FAULT;
            default:  w_select_nxt = SEL_MENU;
        endcase
        w_led_nxt = (w_state_nxt == GO);
    end

    assign number = r_number;
    assign select = r_select;
    assign mode   = r_mode;
    assign led_go = r_led;

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl
// Scoreboard bench for reaction_ctrl: expected output snapshots are queued
// when stimulus is applied and compared when the DUT reaches the matching state.
module tb_reaction_ctrl;

    logic        clk_500Hz = 1'b0;
    logic        rst       = 1'b1;
    logic        btn_mode  = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_react = 1'b0;
    logic [13:0] number;
    logic [1:0]  select;
    logic [1:0]  mode;
    logic        led_go;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string tag;
        int    sel;
        int    num;
        int    md;
        int    led;
    } exp_t;

    exp_t sb[$];

    reaction_ctrl #(
        .DEBOUNCE_TICKS(10),
        .DELAY_BASE(500),
        .LIMIT_EASY_MS(2000),
        .LIMIT_REG_MS(1000),
        .LIMIT_HARD_MS(500)
    ) dut (
        .clk_500Hz(clk_500Hz),
        .rst(rst),
        .btn_mode(btn_mode),
        .btn_start(btn_start),
        .btn_react(btn_react),
        .number(number),
        .select(select),
        .mode(mode),
        .led_go(led_go)
    );

    always #5 clk_500Hz = ~clk_500Hz;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int sel, input int num,
                            input int md, input int led);
        exp_t e;
        e.tag = tag; e.sel = sel; e.num = num; e.md = md; e.led = led;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_empty", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check_val({e.tag, ".select"}, int'(select), e.sel);
            check_val({e.tag, ".number"}, int'(number), e.num);
            check_val({e.tag, ".mode"},   int'(mode),   e.md);
            check_val({e.tag, ".led_go"}, int'(led_go), e.led);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_500Hz);
    endtask

    // which: 0 = mode, 1 = start, 2 = react
    task automatic press(input int which, input int hold);
        @(negedge clk_500Hz);
        case (which)
            0:       btn_mode  = 1'b1;
            1:       btn_start = 1'b1;
            default: btn_react = 1'b1;
        endcase
        cycles(hold);
        btn_mode  = 1'b0;
        btn_start = 1'b0;
        btn_react = 1'b0;
        cycles(20);
    endtask

    task automatic wait_sel(input string tag, input logic [1:0] want, input int budget);
        int k = 0;
        while (select !== want && k < budget) begin
            @(negedge clk_500Hz);
            k++;
        end
        check_val(tag, int'(select === want), 1);
    endtask

    task automatic wait_led(input string tag, input int budget);
        int k = 0;
        while (led_go !== 1'b1 && k < budget) begin
            @(negedge clk_500Hz);
            k++;
        end
        check_val(tag, int'(led_go === 1'b1), 1);
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        push_exp("reset", 0, 0, 0, 0);
        pop_check();
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // Mode cycling in MENU
        for (int i = 1; i <= 3; i++) begin
            push_exp($sformatf("mode_step%0d", i), 0, 0, i % 3, 0);
            press(0, 30);
            pop_check();
        end

        // Short react glitch is swallowed by the debouncer
        push_exp("glitch", 0, 0, 0, 0);
        press(2, 5);
        pop_check();

        // Regular mode, react 100 cycles after GO entry
        press(0, 30);
        @(negedge clk_500Hz);
        btn_start = 1'b1;
        wait_sel("reg_wait_seen", 2'd1, 40);
        push_exp("reg_wait", 1, 0, 1, 0);
        pop_check();
        cycles(20);
        btn_start = 1'b0;
        wait_led("reg_go_seen", 2000);
        push_exp("reg_go_entry", 1, 0, 1, 1);
        pop_check();
        repeat (88) @(posedge clk_500Hz);
        @(negedge clk_500Hz);
        btn_react = 1'b1;
        wait_sel("reg_result_seen", 2'd2, 40);
        push_exp("reg_result", 2, 200, 1, 0);
        pop_check();
        cycles(30);
        btn_react = 1'b0;
        cycles(20);
        push_exp("reg_result_hold", 2, 200, 1, 0);
        pop_check();
        push_exp("reg_back_menu", 0, 0, 1, 0);
        press(1, 30);
        pop_check();

        // Hard mode timeout
        press(0, 30);
        @(negedge clk_500Hz);
        btn_start = 1'b1;
        cycles(30);
        btn_start = 1'b0;
        wait_led("hard_go_seen", 2000);
        repeat (250) @(posedge clk_500Hz);
        @(negedge clk_500Hz);
        push_exp("hard_at_limit", 1, 500, 2, 1);
        pop_check();
        @(negedge clk_500Hz);
        push_exp("hard_fault", 3, 500, 2, 0);
        pop_check();
        push_exp("hard_back_menu", 0, 0, 2, 0);
        press(1, 30);
        pop_check();

        // Early react during WAIT
        @(negedge clk_500Hz);
        btn_start = 1'b1;
        cycles(30);
        btn_start = 1'b0;
        btn_react = 1'b1;
        wait_sel("early_fault_seen", 2'd3, 40);
        push_exp("early_fault", 3, 0, 2, 0);
        pop_check();
        cycles(20);
        btn_react = 1'b0;
        cycles(20);
        push_exp("early_back_menu", 0, 0, 2, 0);
        press(1, 30);
        pop_check();

        // Reset during GO, then mode+start together
        @(negedge clk_500Hz);
        btn_start = 1'b1;
        cycles(30);
        btn_start = 1'b0;
        wait_led("rst_go_seen", 2000);
        cycles(5);
        rst = 1'b1;
        #1;
        push_exp("rst_in_go", 0, 0, 0, 0);
        pop_check();
        @(negedge clk_500Hz);
        rst = 1'b0;
        cycles(2);
        btn_mode  = 1'b1;
        btn_start = 1'b1;
        wait_sel("both_wait_seen", 2'd1, 40);
        push_exp("both_start_wins", 1, 0, 0, 0);
        pop_check();
        cycles(20);
        btn_mode  = 1'b0;
        btn_start = 1'b0;
        cycles(20);
        push_exp("both_mode_held", 1, 0, 0, 0);
        pop_check();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reaction_ctrl.md
# reaction_ctrl

Game controller for the FPGA reaction game: conditions the three raw push-buttons, runs the menu / random-wait / go / result / fault state machine, and times the player's reaction in milliseconds. It is the producer side of the seven-segment display interface: it drives `number`, `select` and `mode` into the display driver, and `led_go` to the board LED. It runs entirely on the 500 Hz tick, so 1 cycle = 2 ms.

## Interface
- `DEBOUNCE_TICKS`, 10: consecutive stable synchronized samples needed to accept a level change (20 ms).
- `DELAY_BASE`, 500: minimum random-wait length in cycles (1000 ms).
- `LIMIT_EASY_MS`, 2000: reaction timeout for easy mode, in ms (must be even, < 9999).
- `LIMIT_REG_MS`, 1000: reaction timeout for regular mode, in ms.
- `LIMIT_HARD_MS`, 500: reaction timeout for hard mode, in ms.

- `clk_500Hz`  in  1  system tick clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_mode`  in  1  raw, asynchronous mode button.
- `btn_start`  in  1  raw, asynchronous start/return button.
- `btn_react`  in  1  raw, asynchronous reaction button.
- `number`  out  14  value in ms: reaction time or timeout.
- `select`  out  2  display state: 0 = mode name, 1 = live count, 2 = result, 3 = blinking fault.
- `mode`  out  2  difficulty: 00 = easy, 01 = regular, 10 = hard; 11 is never driven.
- `led_go`  out  1  high while the player must react.

## Operation
- **Button conditioning, per button.**
  - Two-flop synchronizer, then a debouncer.
  - The debounced level toggles once the synchronized value has differed from it for `DEBOUNCE_TICKS` consecutive cycles. Any agreeing sample clears the count.
  - A rising edge of the debounced level produces a one-cycle pulse (`*_p`).
- **LFSR.** 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1. It advances every cycle in every state.
- **MENU** (`select`=0, `number`=0, `led_go`=0).
  - `mode_p` steps `mode` 00→01→10→00.
  - `start_p` loads `delay_cnt` = `DELAY_BASE` + lfsr[9:0] and goes to WAIT.
  - If `mode_p` and `start_p` arrive together, start wins and `mode` is unchanged.
- **WAIT** (`select`=1, `number`=0, `led_go`=0).
  - `delay_cnt` decrements each cycle; at 0 go to GO.
  - `react_p` goes to FAULT with `number`=0. If `react_p` coincides with expiry, FAULT wins.
- **GO** (`select`=1, `led_go`=1).
  - `number` is 0 on the entry cycle, then +2 per cycle.
  - `react_p` freezes `number` (no increment that cycle) and goes to RESULT.
  - If `number` equals the current mode's limit with no `react_p`, go to FAULT holding `number` = limit.
  - If `react_p` and the limit occur in the same cycle, RESULT wins.
- **RESULT** (`select`=2) and **FAULT** (`select`=3): `number` holds, `led_go`=0. `start_p` returns to MENU and clears `number`.
- `mode` is only writable in MENU; it is held in all other states.
- **Width rule:** `number` never exceeds 9998; the limits guarantee this.

## Timing
- **Reset values:** state MENU, `number`=0, `select`=0, `mode`=00, `led_go`=0, LFSR=16'hACE1, debounced levels 0, debounce counts 0.
- **Reset mid-game:** immediately returns everything to the reset values.
- **Outputs:** all registered, and change on the edge following the triggering pulse.
- **Button latency:** 2 sync cycles + `DEBOUNCE_TICKS` cycles from a stable raw edge to its `*_p`. A raw press shorter than `DEBOUNCE_TICKS` cycles produces no pulse.
- **Measurement resolution:** 2 ms. The reported time excludes debounce latency (fixed offset, documented, not compensated).

## Structure
- **Shared package `reaction_pkg`:**
  - state enum: MENU, WAIT, GO, RESULT, FAULT.
  - `select` codes: SEL_MENU, SEL_COUNT, SEL_RESULT, SEL_FAULT.
  - `mode` codes: MODE_EASY, MODE_REG, MODE_HARD.
  - LFSR seed and tap constants.
- **Sub-module `btn_conditioner`:** synchronizer + debouncer + edge pulse, parameterized by `DEBOUNCE_TICKS`. Instantiated three times.

## Test plan
- Reset, then `btn_mode` held 30 cycles, three times → `mode` goes 01, 10, 00; `select` stays 0.
- `DEBOUNCE_TICKS`=10; `btn_react` glitch lasting 5 cycles in MENU → no pulse, state unchanged.
- Regular mode, start, react 100 cycles after `led_go` rises (pulse timed accordingly) → `select`=2, `number`=200, `led_go`=0.
- Hard mode, start, no react → 250 cycles after GO entry `number`=500, next cycle `select`=3, `number`=500.
- Press react during WAIT → FAULT, `number`=0, `select`=3; `btn_start` → `select`=0, `number`=0.
- Assert `rst` during GO → all outputs at reset values on the same edge; then `mode_p` and `start_p` together → WAIT entered, `mode` unchanged.
